word_serializer: RTL

//  Width-down converter: the transmit-side counterpart of the byte-to-word packer.

---
 rtl/word_serializer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
//   Width-down converter. Accepts DATA_WIDTH_IN-bit words on a valid/ready
//   interface and emits them as DATA_WIDTH_OUT-bit beats with valid/ready
//   backpressure and a last-beat flag. An active shifter plus a one-word
//   pending buffer sustain one beat per cycle across word boundaries.
//
// Parameters
//   DATA_WIDTH_IN   input word width, integer multiple of DATA_WIDTH_OUT
//   DATA_WIDTH_OUT  output beat width
//   MSB_FIRST       1: most-significant slice first, 0: least-significant first
//
// Ports
//   i_clk    in   clock, rising edge
//   i_rst    in   asynchronous active-low reset
//   i_valid  in   input word valid
//   i_data   in   input word
//   o_ready  out  block can accept a word this cycle (registered)
//   o_valid  out  output beat valid
//   o_data   out  output beat
//   o_last   out  current beat is the final slice of its word
//   i_ready  in   downstream accepts the beat this cycle
// -----------------------------------------------------------------------------
module word_serializer #(
   parameter int DATA_WIDTH_IN  = 16,
   parameter int DATA_WIDTH_OUT = 8,
   parameter bit MSB_FIRST      = 1'b1
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_valid,
   input  logic [DATA_WIDTH_IN-1:0]  i_data,
   output logic                      o_ready,
   output logic                      o_valid,
   output logic [DATA_WIDTH_OUT-1:0] o_data,
   output logic                      o_last,
   input  logic                      i_ready
);

   localparam int BEATS = DATA_WIDTH_IN / DATA_WIDTH_OUT;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                     state_q, state_d;
   logic [DATA_WIDTH_IN-1:0]   shift_q, shift_d;
   logic [DATA_WIDTH_IN-1:0]   pend_q, pend_d;
   logic                       pend_full_q, pend_full_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;

   logic                       accept;
   logic                       beat_xfer;
   logic                       at_last;
   logic                       last_xfer;
   int                         slice_idx;
   logic [DATA_WIDTH_IN-1:0]   shifted;

   // o_ready comes straight from a flop, so upstream never sees a
   // combinational path from i_ready or i_valid.
   assign o_ready   = ~pend_full_q;
   assign accept    = i_valid & ~pend_full_q;
   assign o_valid   = (state_q == SHIFT);
   assign at_last   = (cnt_q == LAST_CNT);
   assign beat_xfer = o_valid & i_ready;
   assign last_xfer = beat_xfer & at_last;
   assign o_last    = o_valid & at_last;

   // Slice selection by shifting the active word down; the shifter and count
   // are left untouched on the way to IDLE, so o_data keeps its last value.
   always_comb begin
      slice_idx = MSB_FIRST ? (BEATS - 1 - int'(cnt_q)) : int'(cnt_q);
      shifted   = shift_q >> (slice_idx * DATA_WIDTH_OUT);
      o_data    = shifted[DATA_WIDTH_OUT-1:0];
   end

   // Next-state / datapath control.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      state_d     = state_q;
      shift_d     = shift_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      cnt_d       = cnt_q;

      unique case (state_q)
         IDLE: begin
            // Pending is always empty in IDLE, so an accepted word goes
            // straight into the shifter.
            if (accept) begin
               shift_d = i_data;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (last_xfer) begin
               if (pend_full_q) begin
                  // o_ready is low here, so no new word can arrive this cycle.
                  shift_d     = pend_q;
                  cnt_d       = '0;
                  pend_full_d = 1'b0;
               end else if (accept) begin
                  shift_d = i_data;
                  cnt_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (beat_xfer) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (accept) begin
                  pend_d      = i_data;
                  pend_full_d = 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= IDLE;
         // NOTE: the word registers are reset too, because o_data is defined
         // as zero out of reset and is sliced directly from the shifter.
         shift_q     <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop updating from the
         // values present before the edge.
         state_q     <= state_d;
         shift_q     <= shift_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule
